memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
Shares one single-ported memory bus between instruction fetch (stage_if) and data access (stage_mem) in the 5-stage pipeline. Grants one transaction at a time, holds it until the memory acknowledges or a timeout fires, and returns read data with a one-cycle done pulse. Drives per-requester stall requests into control, which freezes the pipeline while a request is outstanding.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of data buses; byte select width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, max busy cycles without bus_ready before abort; 0 disables timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_request  input  1  fetch read request, held until if_done
if_address  input  ADDRESS_WIDTH  fetch address
if_flush  input  1  discard result of current/pending fetch
if_read_data  output  DATA_WIDTH  fetched word, valid with if_done
if_done  output  1  one-cycle completion pulse, fetch
if_stall_request  output  1  to control: fetch outstanding
mem_request  input  1  data request, held until mem_done
mem_write_enable  input  1  1 = write, 0 = read
mem_address  input  ADDRESS_WIDTH  data address
mem_select  input  DATA_WIDTH/8  byte lane enables
mem_write_data  input  DATA_WIDTH  store data
mem_read_data  output  DATA_WIDTH  load data, valid with mem_done
mem_done  output  1  one-cycle completion pulse, data
mem_stall_request  output  1  to control: data access outstanding
bus_error  output  1  pulses with if_done/mem_done on timeout
bus_chip_enable  output  1  memory access active
bus_write_enable  output  1  memory write strobe
bus_address  output  ADDRESS_WIDTH  memory address
bus_select  output  DATA_WIDTH/8  memory byte enables (all ones for fetch)
bus_write_data  output  DATA_WIDTH  memory write data
bus_read_data  input  DATA_WIDTH  memory read data
bus_ready  input  1  memory acknowledge, sampled only while bus_chip_enable=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset forces state IDLE and clears timeout counter. All outputs are 0, including read data registers. last_grant resets to IF.
- States: IDLE, IF_BUSY, MEM_BUSY. bus_* outputs and done/data/error are registered.
- IDLE arbitration: if only one request is high, grant it. If both are high, grant the requester that was not last granted. After reset this gives MEM priority.
- Grant edge: latch the request fields into the bus_* registers and set bus_chip_enable=1. Move to the *_BUSY state, update last_grant, and clear the counter.
- A fetch drives bus_write_enable=0 and bus_select=all ones.
- BUSY: bus outputs are held stable. On an edge with bus_ready=1:
  - capture bus_read_data into if_read_data or mem_read_data (writes capture 0);
  - pulse the matching done for one cycle;
  - drop bus_chip_enable and return to IDLE.
- Minimum latency is 3 cycles, request to done, when bus_ready is asserted the first busy cycle. Consecutive grants always pass through one IDLE cycle.
- Timeout: the counter increments each BUSY cycle without ready. When it reaches TIMEOUT_CYCLES:
  - the access aborts and bus_chip_enable drops;
  - done pulses with bus_error=1 and read data 0;
  - the FSM returns to IDLE.
  bus_ready on the same edge takes precedence over the timeout.
- Stall requests are combinational: if_stall_request = if_request & ~if_done; mem_stall_request = mem_request & ~mem_done.
- Flush:
  - if_flush in IF_BUSY: the bus transaction completes, but if_done is suppressed and if_read_data is not updated.
  - if_flush in IDLE: blocks the fetch grant that cycle.
- A request deasserted mid-transaction: the transaction still completes and done still pulses.
- Requests are ignored on a cycle where the matching done is high. A held request is therefore not re-granted.
- Reset mid-transaction: bus_chip_enable drops immediately and no done pulse is produced.

Decomposition:
- Shared package memory_arbiter_defines holds:
  - state encodings ARB_IDLE/ARB_IF_BUSY/ARB_MEM_BUSY;
  - grant IDs GRANT_IF/GRANT_MEM;
  - a derived counter width constant.
- No sub-module is required. The timeout counter may optionally be split out as arbiter_timeout_counter.

Test Plan:
- Fetch only: if_request=1, address 0x00000010, bus_ready on first busy cycle, bus_read_data=0x3C010001. Expect bus_address=0x10 and bus_select=0xF one edge after the request. Expect if_done plus if_read_data=0x3C010001 two edges later, and if_stall_request low thereafter.
- Simultaneous requests after reset: MEM granted first, then IF after one IDLE cycle. A second simultaneous pair alternates, giving IF first.
- Store with 3 wait states: mem_write_enable=1, select 0x3, data 0xDEADBEEF. Bus outputs must stay stable for 4 busy cycles. mem_done pulses once with mem_read_data=0, and mem_stall_request stays high until then.
- Timeout with TIMEOUT_CYCLES=4 and bus_ready held 0: abort after 4 busy cycles, mem_done=1 with bus_error=1, bus_chip_enable back to 0.
- if_flush asserted during IF_BUSY: bus completes, if_done stays 0, and the following fetch request is granted normally.
- Reset pulsed mid-MEM_BUSY: all outputs are 0 asynchronously, and the FSM restarts in IDLE on the first clock after release.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// Holds the arbiter state encoding, the grant IDs and the helper that sizes
// the timeout counter from the timeout limit.
package memory_arbiter_defines;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_BUSY  = 2'd1,
        ARB_MEM_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Bits needed to hold values 0..limit; never less than one bit.
    function automatic int unsigned counter_width(input int unsigned limit);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) <= 64'(limit)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    localparam int unsigned TIMEOUT_COUNTER_WIDTH = counter_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/memory_arbiter.sv
// Single-ported memory bus arbiter between instruction fetch and data access.
// Ports:
//   clock, reset                 - clock and asynchronous active-high reset
//   if_request/address/flush     - fetch request side; if_read_data/if_done results
//   mem_request/write_enable/... - data request side; mem_read_data/mem_done results
//   if/mem_stall_request         - combinational stall requests to pipeline control
//   bus_*                        - registered memory bus; bus_read_data/bus_ready return
//   bus_error                    - pulses with a done that ended in a timeout
module memory_arbiter
    import memory_arbiter_defines::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       if_request,
    input  logic [ADDRESS_WIDTH-1:0]   if_address,
    input  logic                       if_flush,
    output logic [DATA_WIDTH-1:0]      if_read_data,
    output logic                       if_done,
    output logic                       if_stall_request,
    input  logic                       mem_request,
    input  logic                       mem_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]   mem_address,
    input  logic [DATA_WIDTH/8-1:0]    mem_select,
    input  logic [DATA_WIDTH-1:0]      mem_write_data,
    output logic [DATA_WIDTH-1:0]      mem_read_data,
    output logic                       mem_done,
    output logic                       mem_stall_request,
    output logic                       bus_error,
    output logic                       bus_chip_enable,
    output logic                       bus_write_enable,
    output logic [ADDRESS_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH/8-1:0]    bus_select,
    output logic [DATA_WIDTH-1:0]      bus_write_data,
    input  logic [DATA_WIDTH-1:0]      bus_read_data,
    input  logic                       bus_ready
);

    localparam int unsigned SELECT_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned COUNT_WIDTH  = counter_width(TIMEOUT_CYCLES);

    arb_state_t                 state, state_d;
    grant_t                     last_grant, last_grant_d;
    logic [COUNT_WIDTH-1:0]     count, count_d;
    logic                       if_flushed, if_flushed_d;

    logic                       bus_chip_enable_d;
    logic                       bus_write_enable_d;
    logic [ADDRESS_WIDTH-1:0]   bus_address_d;
    logic [SELECT_WIDTH-1:0]    bus_select_d;
    logic [DATA_WIDTH-1:0]      bus_write_data_d;
    logic [DATA_WIDTH-1:0]      if_read_data_d;
    logic [DATA_WIDTH-1:0]      mem_read_data_d;
    logic                       if_done_d;
    logic                       mem_done_d;
    logic                       bus_error_d;

    logic                       if_go;
    logic                       mem_go;
    logic                       grant_mem;
    logic                       timeout_hit;
    logic                       fetch_discarded;

    // Stall requests go straight to control, without a register stage.
    assign if_stall_request  = if_request & ~if_done;
    assign mem_stall_request = mem_request & ~mem_done;

    // A request is not eligible on its own done cycle, so a held request is
    // never re-granted; a flush also blocks a fetch grant that cycle.
    assign if_go  = if_request & ~if_done & ~if_flush;
    assign mem_go = mem_request & ~mem_done;

    // On a tie the requester not served last wins.
    assign grant_mem = mem_go & (~if_go | (last_grant == GRANT_IF));

    // Limit zero disables the abort entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // A flush seen at any point of the fetch, including its last cycle, drops it.
    assign fetch_discarded = if_flushed | if_flush;

    // Next-state and next-output logic.
    always_comb begin
        state_d            = state;
        last_grant_d       = last_grant;
        count_d            = count;
        if_flushed_d       = if_flushed;
        bus_chip_enable_d  = bus_chip_enable;
        bus_write_enable_d = bus_write_enable;
        bus_address_d      = bus_address;
        bus_select_d       = bus_select;
        bus_write_data_d   = bus_write_data;
        if_read_data_d     = if_read_data;
        mem_read_data_d    = mem_read_data;
        if_done_d          = 1'b0;
        mem_done_d         = 1'b0;
        bus_error_d        = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (grant_mem) begin
                    state_d            = ARB_MEM_BUSY;
                    last_grant_d       = GRANT_MEM;
                    count_d            = '0;
                    bus_chip_enable_d  = 1'b1;
                    bus_write_enable_d = mem_write_enable;
                    bus_address_d      = mem_address;
                    bus_select_d       = mem_select;
                    bus_write_data_d   = mem_write_data;
                end else if (if_go) begin
                    state_d            = ARB_IF_BUSY;
                    last_grant_d       = GRANT_IF;
                    count_d            = '0;
                    if_flushed_d       = 1'b0;
                    bus_chip_enable_d  = 1'b1;
                    bus_write_enable_d = 1'b0;
                    bus_address_d      = if_address;
                    bus_select_d       = '1;
                    bus_write_data_d   = '0;
                end
            end

            ARB_IF_BUSY: begin
                if_flushed_d = fetch_discarded;
                // Ready on the same edge as the timeout wins.
                if (bus_ready || timeout_hit) begin
                    state_d            = ARB_IDLE;
                    bus_chip_enable_d  = 1'b0;
                    bus_write_enable_d = 1'b0;
                    if (!fetch_discarded) begin
                        if_done_d      = 1'b1;
                        bus_error_d    = ~bus_ready;
                        if_read_data_d = bus_ready ? bus_read_data : '0;
                    end
                end else begin
                    count_d = count + COUNT_WIDTH'(1);
                end
            end

            ARB_MEM_BUSY: begin
                if (bus_ready || timeout_hit) begin
                    state_d            = ARB_IDLE;
                    bus_chip_enable_d  = 1'b0;
                    bus_write_enable_d = 1'b0;
                    mem_done_d         = 1'b1;
                    bus_error_d        = ~bus_ready;
                    // Stores and aborted accesses return zero.
                    mem_read_data_d    = (bus_ready && !bus_write_enable) ? bus_read_data : '0;
                end else begin
                    count_d = count + COUNT_WIDTH'(1);
                end
            end

            default: begin
                state_d           = ARB_IDLE;
                bus_chip_enable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ARB_IDLE;
            last_grant       <= GRANT_IF;
            count            <= '0;
            if_flushed       <= 1'b0;
            bus_chip_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_address      <= '0;
            bus_select       <= '0;
            bus_write_data   <= '0;
            if_read_data     <= '0;
            mem_read_data    <= '0;
            if_done          <= 1'b0;
            mem_done         <= 1'b0;
            bus_error        <= 1'b0;
        end else begin
            state            <= state_d;
            last_grant       <= last_grant_d;
            count            <= count_d;
            if_flushed       <= if_flushed_d;
            bus_chip_enable  <= bus_chip_enable_d;
            bus_write_enable <= bus_write_enable_d;
            bus_address      <= bus_address_d;
            bus_select       <= bus_select_d;
            bus_write_data   <= bus_write_data_d;
            if_read_data     <= if_read_data_d;
            mem_read_data    <= mem_read_data_d;
            if_done          <= if_done_d;
            mem_done         <= mem_done_d;
            bus_error        <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: fetch, arbitration, store with
// wait states, timeout, flush and mid-transaction reset.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_request = 1'b0;
    logic [31:0] if_address = '0;
    logic        if_flush = 1'b0;
    logic [31:0] if_read_data;
    logic        if_done;
    logic        if_stall_request;
    logic        mem_request = 1'b0;
    logic        mem_write_enable = 1'b0;
    logic [31:0] mem_address = '0;
    logic [3:0]  mem_select = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        mem_done;
    logic        mem_stall_request;
    logic        bus_error;
    logic        bus_chip_enable;
    logic        bus_write_enable;
    logic [31:0] bus_address;
    logic [3:0]  bus_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data = '0;
    logic        bus_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] last_if_data = '0;

    // Memory responder settings
    int busy_cnt    = 0;
    int wait_states = 0;
    bit ready_en    = 1'b1;

    memory_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .if_request       (if_request),
        .if_address       (if_address),
        .if_flush         (if_flush),
        .if_read_data     (if_read_data),
        .if_done          (if_done),
        .if_stall_request (if_stall_request),
        .mem_request      (mem_request),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_select       (mem_select),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_done         (mem_done),
        .mem_stall_request(mem_stall_request),
        .bus_error        (bus_error),
        .bus_chip_enable  (bus_chip_enable),
        .bus_write_enable (bus_write_enable),
        .bus_address      (bus_address),
        .bus_select       (bus_select),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .bus_ready        (bus_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h3C01_0001;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: raises ready after wait_states busy cycles.
    always @(negedge clock) begin
        if (bus_chip_enable) begin
            busy_cnt      = busy_cnt + 1;
            bus_ready     = ready_en && (busy_cnt > wait_states);
            bus_read_data = model_word(bus_address);
        end else begin
            busy_cnt      = 0;
            bus_ready     = 1'b0;
            bus_read_data = 32'h0BAD_0000;
        end
    end

    task automatic push_exp(input bit is_mem, input logic [31:0] data, input bit err);
        exp_t e;
        e.is_mem = is_mem;
        e.data   = data;
        e.err    = err;
        exp_q.push_back(e);
        if (!is_mem && !err) last_if_data = data;
    endtask

    // Waits (bounded) for a done pulse; reports which one and after how many negedges.
    task automatic wait_done(input int budget, output bit got_if, output bit got_mem, output int cycles);
        got_if  = 1'b0;
        got_mem = 1'b0;
        cycles  = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (if_done || mem_done) begin
                got_if  = if_done;
                got_mem = mem_done;
                cycles  = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if ({bus_chip_enable, bus_write_enable, bus_address, bus_select, bus_write_data,
             if_read_data, mem_read_data, if_done, mem_done, bus_error} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ce=%b addr=%h ifrd=%h memrd=%h done=%b%b err=%b, expected all 0",
                     bus_chip_enable, bus_address, if_read_data, mem_read_data, if_done, mem_done, bus_error);
        end
        n_cmp++;
        if ({if_stall_request, mem_stall_request} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_stall: got %b%b expected 00", if_stall_request, mem_stall_request);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        bit gi, gm;
        int cyc;
        exp_t e;
        if_request = 1'b1;
        if_address = 32'h0000_0010;
        push_exp(1'b0, 32'h3C01_0001, 1'b0);
        @(negedge clock);
        n_cmp++;
        if ({bus_chip_enable, bus_write_enable, bus_address, bus_select, if_stall_request} !==
            {1'b1, 1'b0, 32'h0000_0010, 4'hF, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_grant: got ce=%b we=%b addr=%h sel=%h stall=%b expected ce=1 we=0 addr=00000010 sel=f stall=1",
                     bus_chip_enable, bus_write_enable, bus_address, bus_select, if_stall_request);
        end
        wait_done(8, gi, gm, cyc);
        n_cmp++;
        if ({gi, gm, cyc} !== {1'b1, 1'b0, 32'd1}) begin
            n_err++;
            $display("FAIL fetch_done: got if=%b mem=%b after %0d, expected if=1 mem=0 after 1", gi, gm, cyc);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({1'b0, if_read_data, bus_error} !== {e.is_mem, e.data, e.err}) begin
            n_err++;
            $display("FAIL fetch_data: got %h err=%b expected %h err=%b", if_read_data, bus_error, e.data, e.err);
        end
        n_cmp++;
        if (if_stall_request !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_stall_drop: got %b expected 0", if_stall_request);
        end
        if_request = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({if_done, bus_chip_enable, if_stall_request} !== 3'b000) begin
            n_err++;
            $display("FAIL fetch_after: got done=%b ce=%b stall=%b expected 000", if_done, bus_chip_enable, if_stall_request);
        end
    endtask

    // Serves one done from the scoreboard: checks which requester and its data.
    task automatic test_arbitrate_pair(input string tag, input logic [31:0] if_a, input logic [31:0] mem_a,
                                       input bit mem_first);
        bit gi, gm;
        int cyc;
        exp_t e;
        if_request  = 1'b1;
        if_address  = if_a;
        mem_request = 1'b1;
        mem_write_enable = 1'b0;
        mem_address = mem_a;
        mem_select  = 4'hF;
        if (mem_first) begin
            push_exp(1'b1, model_word(mem_a), 1'b0);
            push_exp(1'b0, model_word(if_a), 1'b0);
        end else begin
            push_exp(1'b0, model_word(if_a), 1'b0);
            push_exp(1'b1, model_word(mem_a), 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            wait_done(8, gi, gm, cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gm, gi, cyc} !== {e.is_mem, ~e.is_mem, 32'd2}) begin
                n_err++;
                $display("FAIL %s_order%0d: got mem=%b if=%b after %0d, expected mem=%b if=%b after 2",
                         tag, k, gm, gi, cyc, e.is_mem, ~e.is_mem);
            end
            n_cmp++;
            if ({(gm ? mem_read_data : if_read_data), bus_error, bus_chip_enable} !== {e.data, e.err, 1'b0}) begin
                n_err++;
                $display("FAIL %s_data%0d: got %h err=%b ce=%b expected %h err=%b ce=0",
                         tag, k, (gm ? mem_read_data : if_read_data), bus_error, bus_chip_enable, e.data, e.err);
            end
            if (gm) mem_request = 1'b0;
            if (gi) if_request = 1'b0;
        end
        if_request  = 1'b0;
        mem_request = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_priority();
        bit gi, gm;
        int cyc;
        exp_t e;
        // After reset MEM wins the tie, then IF follows.
        test_arbitrate_pair("pair1", 32'h0000_0100, 32'h0000_0200, 1'b1);
        // A lone data access makes MEM the last grant.
        mem_request = 1'b1;
        mem_address = 32'h0000_0300;
        push_exp(1'b1, model_word(32'h0000_0300), 1'b0);
        wait_done(8, gi, gm, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({gm, mem_read_data} !== {1'b1, e.data}) begin
            n_err++;
            $display("FAIL mem_only: got done=%b data=%h expected done=1 data=%h", gm, mem_read_data, e.data);
        end
        mem_request = 1'b0;
        @(negedge clock);
        // Tie again: IF now wins.
        test_arbitrate_pair("pair2", 32'h0000_0104, 32'h0000_0204, 1'b0);
    endtask

    task automatic test_store_wait();
        exp_t e;
        wait_states      = 3;
        mem_request      = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = 32'h0000_0040;
        mem_select       = 4'h3;
        mem_write_data   = 32'hDEAD_BEEF;
        push_exp(1'b1, 32'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({bus_chip_enable, bus_write_enable, bus_address, bus_select, bus_write_data, mem_done, mem_stall_request} !==
                {1'b1, 1'b1, 32'h0000_0040, 4'h3, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL store_hold%0d: got ce=%b we=%b addr=%h sel=%h wd=%h done=%b stall=%b expected 1 1 00000040 3 deadbeef 0 1",
                         c, bus_chip_enable, bus_write_enable, bus_address, bus_select, bus_write_data, mem_done, mem_stall_request);
            end
        end
        @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++;
        if ({mem_done, mem_read_data, bus_error, mem_stall_request} !== {1'b1, e.data, e.err, 1'b0}) begin
            n_err++;
            $display("FAIL store_done: got done=%b data=%h err=%b stall=%b expected done=1 data=%h err=%b stall=0",
                     mem_done, mem_read_data, bus_error, mem_stall_request, e.data, e.err);
        end
        mem_request      = 1'b0;
        mem_write_enable = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({mem_done, bus_chip_enable} !== 2'b00) begin
            n_err++;
            $display("FAIL store_single_pulse: got done=%b ce=%b expected 00", mem_done, bus_chip_enable);
        end
        wait_states = 0;
    endtask

    task automatic test_timeout();
        exp_t e;
        ready_en    = 1'b0;
        mem_request = 1'b1;
        mem_address = 32'h0000_0080;
        mem_select  = 4'hF;
        push_exp(1'b1, 32'h0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({bus_chip_enable, mem_done} !== 2'b10) begin
                n_err++;
                $display("FAIL timeout_busy%0d: got ce=%b done=%b expected ce=1 done=0", c, bus_chip_enable, mem_done);
            end
        end
        @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++;
        if ({mem_done, mem_read_data, bus_error, bus_chip_enable} !== {1'b1, e.data, e.err, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_abort: got done=%b data=%h err=%b ce=%b expected done=1 data=%h err=%b ce=0",
                     mem_done, mem_read_data, bus_error, bus_chip_enable, e.data, e.err);
        end
        mem_request = 1'b0;
        ready_en    = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({bus_error, mem_done} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_pulse: got err=%b done=%b expected 00", bus_error, mem_done);
        end
    endtask

    task automatic test_flush();
        bit gi, gm, seen_done, completed;
        int cyc;
        exp_t e;
        wait_states = 2;
        if_request  = 1'b1;
        if_address  = 32'h0000_0020;
        @(negedge clock);
        n_cmp++;
        if (bus_chip_enable !== 1'b1) begin
            n_err++;
            $display("FAIL flush_grant: got ce=%b expected 1", bus_chip_enable);
        end
        if_flush = 1'b1;
        @(negedge clock);
        if_flush   = 1'b0;
        if_address = 32'h0000_0024;
        seen_done  = if_done;
        completed  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (if_done) seen_done = 1'b1;
            if (!bus_chip_enable) begin
                completed = 1'b1;
                break;
            end
        end
        n_cmp++;
        if ({completed, seen_done, if_read_data} !== {1'b1, 1'b0, last_if_data}) begin
            n_err++;
            $display("FAIL flush_suppress: got completed=%b done_seen=%b data=%h expected 1 0 %h",
                     completed, seen_done, if_read_data, last_if_data);
        end
        push_exp(1'b0, model_word(32'h0000_0024), 1'b0);
        wait_done(12, gi, gm, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({gi, gm, if_read_data, bus_error} !== {1'b1, 1'b0, e.data, e.err}) begin
            n_err++;
            $display("FAIL flush_refetch: got if=%b mem=%b data=%h err=%b expected 1 0 %h %b",
                     gi, gm, if_read_data, bus_error, e.data, e.err);
        end
        if_request  = 1'b0;
        wait_states = 0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit gi, gm;
        int cyc;
        exp_t e;
        wait_states = 5;
        mem_request = 1'b1;
        mem_address = 32'h0000_0090;
        mem_select  = 4'hF;
        @(negedge clock);
        n_cmp++;
        if (bus_chip_enable !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_busy: got ce=%b expected 1", bus_chip_enable);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus_chip_enable, bus_write_enable, bus_address, bus_select, bus_write_data,
             if_read_data, mem_read_data, if_done, mem_done, bus_error} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: got ce=%b addr=%h ifrd=%h memrd=%h done=%b%b expected all 0",
                     bus_chip_enable, bus_address, if_read_data, mem_read_data, if_done, mem_done);
        end
        mem_request = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({bus_chip_enable, mem_done} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_hold: got ce=%b done=%b expected 00", bus_chip_enable, mem_done);
        end
        reset       = 1'b0;
        wait_states = 0;
        mem_request = 1'b1;
        mem_address = 32'h0000_0094;
        push_exp(1'b1, model_word(32'h0000_0094), 1'b0);
        @(negedge clock);
        n_cmp++;
        if ({bus_chip_enable, bus_address} !== {1'b1, 32'h0000_0094}) begin
            n_err++;
            $display("FAIL rst_restart: got ce=%b addr=%h expected ce=1 addr=00000094", bus_chip_enable, bus_address);
        end
        wait_done(8, gi, gm, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({gm, cyc, mem_read_data} !== {1'b1, 32'd1, e.data}) begin
            n_err++;
            $display("FAIL rst_restart_done: got done=%b after %0d data=%h expected 1 after 1 data=%h",
                     gm, cyc, mem_read_data, e.data);
        end
        mem_request = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store_wait();
        test_timeout();
        test_flush();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
